// File: rtl/snake_pkg.sv
// snake_pkg: shared types, default grid constants and init positions for the snake game
//   dir_t   - movement direction
//   state_t - controller states
//   cell_t  - grid cell coordinate {cx, cy}
package snake_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [2:0] {IDLE, RUN, CALC, UPDATE, FOOD, GAME_OVER} state_t;

    typedef struct packed {
        logic [4:0] cx;
        logic [3:0] cy;
    } cell_t;

    localparam int DEF_GRID_W          = 20;
    localparam int DEF_GRID_H          = 15;
    localparam int DEF_MAX_LEN         = 32;
    localparam int DEF_FRAMES_PER_STEP = 8;

    localparam cell_t       INIT_HEAD = '{cx: 5'd10, cy: 4'd7};
    localparam cell_t       INIT_MID  = '{cx: 5'd9,  cy: 4'd7};
    localparam cell_t       INIT_TAIL = '{cx: 5'd8,  cy: 4'd7};
    localparam cell_t       INIT_FOOD = '{cx: 5'd15, cy: 4'd7};
    localparam logic [5:0]  INIT_LEN  = 6'd3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/snake_lfsr.sv
// snake_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) producing food candidates
//   clk, reset - clock, async active-high reset (loads seed)
//   seed       - value loaded on reset
//   cand       - candidate cell {lfsr[4:0], lfsr[12:9]}
module snake_lfsr
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output cell_t       cand
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset)
        if (reset) lfsr <= seed;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign cand = '{cx: lfsr[4:0], cy: lfsr[12:9]};

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake game logic stepped by vsync frames, with a registered cell-query port
//   clk, reset                    - clock, async active-high reset
//   vsync                         - active-low VGA vsync; its falling edge is the frame tick
//   start                         - start / restart pulse
//   btn_up/down/left/right        - synchronized direction buttons
//   query_cx, query_cy            - cell to look up; query_snake/query_food valid next cycle
//   head_cx, head_cy, length      - snake head cell and length
//   score                         - foods eaten, saturating
//   running, game_over            - game status flags
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W          = DEF_GRID_W,
    parameter int GRID_H          = DEF_GRID_H,
    parameter int MAX_LEN         = DEF_MAX_LEN,
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [4:0] query_cx,
    input  logic [3:0] query_cy,
    output logic       query_snake,
    output logic       query_food,
    output logic [4:0] head_cx,
    output logic [3:0] head_cy,
    output logic [5:0] length,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int FW    = $clog2(FRAMES_PER_STEP);
    // the three initial body cells are adjacent in one row, tail first
    localparam logic [NCELL-1:0] INIT_MAP =
        NCELL'(7) << (int'(INIT_TAIL.cy) * GRID_W + int'(INIT_TAIL.cx));

    state_t           state;
    dir_t             dir, pending_dir;
    cell_t            body [MAX_LEN];
    logic [PW-1:0]    head_ptr, tail_ptr;
    logic [NCELL-1:0] bitmap;
    cell_t            food, next_q, nxt, tail, cand, query_cell;
    logic             food_valid, eat_q, grow_q;
    logic             vsync_q, step_pend;
    logic [FW-1:0]    frame_cnt;
    logic             tick, frame_wrap, wall, eat, grow, hit, cand_ok;

    function automatic logic [IW-1:0] idx(input cell_t c);
        return IW'(int'(c.cy) * GRID_W + int'(c.cx));
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (int'(p) == MAX_LEN - 1) ? '0 : p + PW'(1);
    endfunction

    function automatic logic in_grid(input cell_t c);
        return int'(c.cx) < GRID_W && int'(c.cy) < GRID_H;
    endfunction

    snake_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .cand  (cand)
    );

    always_comb begin
        tick       = vsync_q & ~vsync;
        frame_wrap = tick && running && int'(frame_cnt) == FRAMES_PER_STEP - 1;
        tail       = body[tail_ptr];
        nxt        = '{cx: pending_dir == LEFT ? head_cx - 5'd1 : pending_dir == RIGHT ? head_cx + 5'd1 : head_cx,
                       cy: pending_dir == UP ? head_cy - 4'd1 : pending_dir == DOWN ? head_cy + 4'd1 : head_cy};
        wall       = (pending_dir == UP && head_cy == '0) || (pending_dir == DOWN && int'(head_cy) == GRID_H - 1) ||
                     (pending_dir == LEFT && head_cx == '0) || (pending_dir == RIGHT && int'(head_cx) == GRID_W - 1);
        eat        = food_valid && nxt == food;
        grow       = eat && int'(length) < MAX_LEN;
        // moving into the tail is legal only when the tail moves away this step
        hit        = wall || (bitmap[idx(nxt)] && (nxt != tail || grow));
        cand_ok    = in_grid(cand) && !bitmap[idx(cand)];
        query_cell = '{cx: query_cx, cy: query_cy};
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            query_snake <= 1'b0;
            query_food  <= 1'b0;
        end else begin
            query_snake <= in_grid(query_cell) && bitmap[idx(query_cell)];
            query_food  <= in_grid(query_cell) && food_valid && query_cell == food;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            running     <= 1'b0;
            game_over   <= 1'b0;
            vsync_q     <= 1'b1;
            frame_cnt   <= '0;
            step_pend   <= 1'b0;
            dir         <= RIGHT;
            pending_dir <= RIGHT;
            for (int i = 0; i < MAX_LEN; i++) body[i] <= '0;
            body[0]     <= INIT_TAIL;
            body[1]     <= INIT_MID;
            body[2]     <= INIT_HEAD;
            head_ptr    <= PW'(2);
            tail_ptr    <= '0;
            bitmap      <= INIT_MAP;
            head_cx     <= INIT_HEAD.cx;
            head_cy     <= INIT_HEAD.cy;
            length      <= INIT_LEN;
            score       <= '0;
            food        <= INIT_FOOD;
            food_valid  <= 1'b1;
            next_q      <= '0;
            eat_q       <= 1'b0;
            grow_q      <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            pending_dir <= (btn_up && dir != DOWN) ? UP : (btn_down && dir != UP) ? DOWN :
                           (btn_left && dir != RIGHT) ? LEFT : (btn_right && dir != LEFT) ? RIGHT : pending_dir;
            if (running && tick) frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
            // a wrap always wins so a tick landing on the RUN->CALC edge is not lost
            if (frame_wrap) step_pend <= 1'b1;
            else if (state == RUN) step_pend <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (step_pend) state <= CALC;
                CALC: begin
                    dir    <= pending_dir;
                    next_q <= nxt;
                    eat_q  <= eat;
                    grow_q <= grow;
                    if (hit) begin
                        state     <= GAME_OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                    end else state <= UPDATE;
                end
                UPDATE: begin
                    head_ptr             <= inc(head_ptr);
                    body[inc(head_ptr)]  <= next_q;
                    head_cx              <= next_q.cx;
                    head_cy              <= next_q.cy;
                    if (!grow_q) begin
                        bitmap[idx(body[tail_ptr])] <= 1'b0;
                        tail_ptr                    <= inc(tail_ptr);
                    end
                    // set after the tail clear so a head entering the old tail cell stays marked
                    bitmap[idx(next_q)] <= 1'b1;
                    if (grow_q) length <= length + 6'd1;
                    if (eat_q) begin
                        score      <= score == 8'hFF ? score : score + 8'd1;
                        food_valid <= 1'b0;
                        state      <= FOOD;
                    end else state <= RUN;
                end
                FOOD: if (cand_ok) begin
                    food       <= cand;
                    food_valid <= 1'b1;
                    state      <= RUN;
                end
                GAME_OVER: if (start) begin
                    state       <= RUN;
                    running     <= 1'b1;
                    game_over   <= 1'b0;
                    frame_cnt   <= '0;
                    step_pend   <= 1'b0;
                    dir         <= RIGHT;
                    pending_dir <= RIGHT;
                    body[0]     <= INIT_TAIL;
                    body[1]     <= INIT_MID;
                    body[2]     <= INIT_HEAD;
                    head_ptr    <= PW'(2);
                    tail_ptr    <= '0;
                    bitmap      <= INIT_MAP;
                    head_cx     <= INIT_HEAD.cx;
                    head_cy     <= INIT_HEAD.cy;
                    length      <= INIT_LEN;
                    score       <= '0;
                    food        <= INIT_FOOD;
                    food_valid  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end

endmodule
